joy_sar_scanner: RTL and testbench

- Hardware initiator for the joystick-comparator interface: drives the 6-bit DAC value and the SELA/SELB mux selects, then reads back the HILO comparator bit.
- Runs a 6-step successive-approximation search on each enabled joystick channel and latches four 6-bit axis values.
- Sits beside the PIA in the CoCo2 top level. While busy it owns DAC/SEL through a top-level mux, so debug/OSD logic can read joysticks without the CPU ROM routine.

---
 rtl/joy_sar_scanner.sv | 199 +++++++++++++++++++
 tb/tb_joy_sar_scanner.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/joy_sar_scanner.sv
// Joystick successive-approximation scanner: drives the DAC and SELA/SELB
// mux selects, reads the HILO comparator bit back, and latches a 6-bit axis
// value for each enabled channel.
module joy_sar_scanner #(
  parameter int unsigned SETTLE    = 2,
  parameter logic [3:0]  CHAN_MASK = 4'b1111
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       hilo,
  output logic [5:0] dac_out,
  output logic       sela,
  output logic       selb,
  output logic       dac_own,
  output logic       busy,
  output logic       done,
  output logic [5:0] joy0,
  output logic [5:0] joy1,
  output logic [5:0] joy2,
  output logic [5:0] joy3,
  output logic       aborted
);

  typedef enum logic [2:0] {
    IDLE,
    TRIAL,
    WAIT,
    SAMPLE,
    NEXTCH,
    FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      acc_q, acc_d;
  logic [2:0]      bit_q, bit_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      ch_q, ch_d;
  logic [1:0]      sel_q, sel_d;
  logic [5:0]      dac_q, dac_d;
  logic            own_q, own_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            aborted_q, aborted_d;
  logic [3:0][5:0] joy_q, joy_d;

  logic [1:0]      firstCh;
  logic [1:0]      nextCh;
  logic            haveNext;
  logic [5:0]      bitMask;

  // Lowest enabled channel overall, and lowest enabled channel above the current one.
  always_comb begin
    firstCh  = 2'd0;
    nextCh   = 2'd0;
    haveNext = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (CHAN_MASK[i]) begin
        firstCh = 2'(i);
        if (2'(i) > ch_q) begin
          nextCh   = 2'(i);
          haveNext = 1'b1;
        end
      end
    end
  end

  assign bitMask = 6'b1 << bit_q;

  // Next-state logic for the search; abort overrides everything outside IDLE.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    bit_d     = bit_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    sel_d     = sel_q;
    dac_d     = dac_q;
    own_d     = own_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    joy_d     = joy_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (CHAN_MASK != 4'b0000) begin
            state_d = TRIAL;
            busy_d  = 1'b1;
            own_d   = 1'b1;
            ch_d    = firstCh;
            acc_d   = 6'd0;
            bit_d   = 3'd5;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      TRIAL: begin
        dac_d   = acc_q | bitMask;
        sel_d   = ch_q;
        cnt_d   = 4'(SETTLE - 1);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        acc_d = hilo ? (acc_q | bitMask) : (acc_q & ~bitMask);
        if (bit_q == 3'd0) begin
          joy_d[ch_q] = acc_d;
          state_d     = NEXTCH;
        end else begin
          bit_d   = bit_q - 3'd1;
          state_d = TRIAL;
        end
      end
      NEXTCH: begin
        if (haveNext) begin
          ch_d    = nextCh;
          acc_d   = 6'd0;
          bit_d   = 3'd5;
          state_d = TRIAL;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          own_d   = 1'b0;
          dac_d   = 6'd0;
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      aborted_d = 1'b1;
      done_d    = 1'b0;
      busy_d    = 1'b0;
      own_d     = 1'b0;
      dac_d     = 6'd0;
      joy_d     = joy_q;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      acc_q     <= 6'd0;
      bit_q     <= 3'd5;
      cnt_q     <= 4'd0;
      ch_q      <= 2'd0;
      sel_q     <= 2'd0;
      dac_q     <= 6'd0;
      own_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      joy_q     <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      ch_q      <= ch_d;
      sel_q     <= sel_d;
      dac_q     <= dac_d;
      own_q     <= own_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      joy_q     <= joy_d;
    end
  end

  assign dac_out = dac_q;
  assign sela    = sel_q[0];
  assign selb    = sel_q[1];
  assign dac_own = own_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign joy0    = joy_q[0];
  assign joy1    = joy_q[1];
  assign joy2    = joy_q[2];
  assign joy3    = joy_q[3];

endmodule

// File: tb/tb_joy_sar_scanner.sv
// Testbench for joy_sar_scanner: three instances with different settle times
// and channel masks, driven against a registered-comparator model.
module tb_joy_sar_scanner;

  logic clk = 1'b0;
  logic reset_n;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  logic       startA[3];
  logic       abortA[3];
  logic       hiloA[3];
  logic [5:0] dacA[3];
  logic       selaA[3];
  logic       selbA[3];
  logic       ownA[3];
  logic       busyA[3];
  logic       doneA[3];
  logic       abortedA[3];
  logic [5:0] joyA[3][4];

  int         axis[3][4];
  int         expJoy[3][4];
  int         settleOf[3] = '{2, 5, 2};
  logic [3:0] maskOf[3]   = '{4'b1111, 4'b0101, 4'b0000};

  int checks = 0;
  int errors = 0;

  joy_sar_scanner #(.SETTLE(2), .CHAN_MASK(4'b1111)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(startA[0]), .abort(abortA[0]), .hilo(hiloA[0]),
    .dac_out(dacA[0]), .sela(selaA[0]), .selb(selbA[0]), .dac_own(ownA[0]), .busy(busyA[0]),
    .done(doneA[0]), .joy0(joyA[0][0]), .joy1(joyA[0][1]), .joy2(joyA[0][2]), .joy3(joyA[0][3]),
    .aborted(abortedA[0])
  );

  joy_sar_scanner #(.SETTLE(5), .CHAN_MASK(4'b0101)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(startA[1]), .abort(abortA[1]), .hilo(hiloA[1]),
    .dac_out(dacA[1]), .sela(selaA[1]), .selb(selbA[1]), .dac_own(ownA[1]), .busy(busyA[1]),
    .done(doneA[1]), .joy0(joyA[1][0]), .joy1(joyA[1][1]), .joy2(joyA[1][2]), .joy3(joyA[1][3]),
    .aborted(abortedA[1])
  );

  joy_sar_scanner #(.SETTLE(2), .CHAN_MASK(4'b0000)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(startA[2]), .abort(abortA[2]), .hilo(hiloA[2]),
    .dac_out(dacA[2]), .sela(selaA[2]), .selb(selbA[2]), .dac_own(ownA[2]), .busy(busyA[2]),
    .done(doneA[2]), .joy0(joyA[2][0]), .joy1(joyA[2][1]), .joy2(joyA[2][2]), .joy3(joyA[2][3]),
    .aborted(abortedA[2])
  );

  // Comparator model: registers (selected axis >= dac) one clock after dac/sel change.
  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      hiloA[u] <= (axis[u][{selbA[u], selaA[u]}] >= int'(dacA[u]));
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Trial value presented for bit step i (0 = MSB) of a binary search for ax.
  function automatic int trialOf(input int ax, input int i);
    int v = 0;
    int t;
    for (int k = 0; k <= i; k++) begin
      t = v | (1 << (5 - k));
      if (k == i) return t;
      if (ax >= t) v = t;
    end
    return 0;
  endfunction

  function automatic int chanCount(input int u);
    int n = 0;
    for (int ch = 0; ch < 4; ch++) if (maskOf[u][ch]) n++;
    return n;
  endfunction

  function automatic int totalOf(input int u);
    return 1 + chanCount(u) * (6 * (settleOf[u] + 1) + 1);
  endfunction

  task automatic checkAllZero(input string tag);
    for (int u = 0; u < 3; u++) begin
      checkOutput($sformatf("%s u%0d dac", tag, u), dacA[u], 0);
      checkOutput($sformatf("%s u%0d sel", tag, u), {selbA[u], selaA[u]}, 0);
      checkOutput($sformatf("%s u%0d own", tag, u), ownA[u], 0);
      checkOutput($sformatf("%s u%0d busy", tag, u), busyA[u], 0);
      checkOutput($sformatf("%s u%0d done", tag, u), doneA[u], 0);
      checkOutput($sformatf("%s u%0d aborted", tag, u), abortedA[u], 0);
      for (int ch = 0; ch < 4; ch++)
        checkOutput($sformatf("%s u%0d joy%0d", tag, u, ch), joyA[u][ch], 0);
    end
  endtask

  // One scan on unit u; abortAt = window in which abort is driven (0 = none).
  // Window 0 is the cycle start is driven; window c is observed #1 after the c-th edge.
  task automatic applyStimulus(input int u, input int abortAt);
    int s       = settleOf[u];
    int per     = 6 * (s + 1) + 1;
    int nch     = chanCount(u);
    int total   = totalOf(u);
    int endWin  = (abortAt > 0) ? abortAt + 1 : total;
    int chList[$];
    bit running;
    int j, o, i, p;
    for (int ch = 0; ch < 4; ch++) if (maskOf[u][ch]) chList.push_back(ch);

    @(posedge clk); #1;
    startA[u] = 1'b1;
    for (int c = 1; c <= endWin + 1; c++) begin
      @(posedge clk); #1;
      startA[u] = 1'b0;
      abortA[u] = 1'b0;
      running = (c < total) && (abortAt == 0 || c <= abortAt);
      checkOutput($sformatf("u%0d c%0d done", u, c), doneA[u], (abortAt == 0 && c == total));
      checkOutput($sformatf("u%0d c%0d aborted", u, c), abortedA[u], (abortAt > 0 && c == abortAt + 1));
      checkOutput($sformatf("u%0d c%0d busy", u, c), busyA[u], running);
      checkOutput($sformatf("u%0d c%0d own", u, c), ownA[u], running);
      if (!running && c >= endWin)
        checkOutput($sformatf("u%0d c%0d dac idle", u, c), dacA[u], 0);
      if (running) begin
        j = (c - 1) / per;
        o = (c - 1) % per;
        if (j < nch && o < 6 * (s + 1)) begin
          i = o / (s + 1);
          p = o % (s + 1);
          if (p >= 1) begin
            checkOutput($sformatf("u%0d c%0d dac", u, c), dacA[u], trialOf(axis[u][chList[j]], i));
            checkOutput($sformatf("u%0d c%0d sel", u, c), {selbA[u], selaA[u]}, chList[j]);
          end
        end
      end
      if (c >= 2 && c < endWin && $urandom_range(0, 9) == 0) startA[u] = 1'b1;
      if (c == abortAt) abortA[u] = 1'b1;
    end

    for (int k = 0; k < nch; k++) begin
      if (abortAt == 0 || abortAt >= 1 + k * per + 6 * (s + 1))
        expJoy[u][chList[k]] = axis[u][chList[k]];
    end
    for (int ch = 0; ch < 4; ch++)
      checkOutput($sformatf("u%0d joy%0d", u, ch), joyA[u][ch], expJoy[u][ch]);
  endtask

  task automatic randomAxes(input int u);
    for (int ch = 0; ch < 4; ch++) axis[u][ch] = $urandom_range(0, 63);
  endtask

  // Directed cases followed by randomized scans, aborts and a mid-scan reset.
  initial begin
    int u;
    int ab;
    for (int k = 0; k < 3; k++) begin
      startA[k] = 1'b0;
      abortA[k] = 1'b0;
      for (int ch = 0; ch < 4; ch++) begin
        axis[k][ch]   = 0;
        expJoy[k][ch] = 0;
      end
    end
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset_n = 1'b1;

    axis[0] = '{37, 5, 9, 11};
    applyStimulus(0, 0);

    axis[0] = '{0, 63, 1, 62};
    applyStimulus(0, 0);

    axis[1] = '{63, 7, 20, 33};
    applyStimulus(1, 0);

    applyStimulus(2, 0);

    randomAxes(0);
    applyStimulus(0, 1 + 19 + $urandom_range(0, 17));

    repeat (8) begin
      u = $urandom_range(0, 1);
      randomAxes(u);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, totalOf(u) - 1) : 0;
      applyStimulus(u, ab);
    end

    randomAxes(0);
    @(posedge clk); #1;
    startA[0] = 1'b1;
    @(posedge clk); #1;
    startA[0] = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checkAllZero("midreset");
    for (int k = 0; k < 3; k++)
      for (int ch = 0; ch < 4; ch++) expJoy[k][ch] = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    randomAxes(0);
    applyStimulus(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
